// File: rtl/mul_div_unit.sv
// Iterative 16-bit multiply/divide unit, one result bit per cycle,
// with a single-cycle register-file write-back at completion.
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [AW-1:0]    dest,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             wb_en,
    output logic [AW-1:0]    wb_dest,
    output logic [WIDTH-1:0] wb_data
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  dest_q, dest_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] a_raw_q, a_raw_d;
    logic        bz_q, bz_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] q_q, q_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] hi_q, hi_d;
    logic        dbz_q, dbz_d;
    logic        done_q, done_d;
    logic [2:0]  wbd_q, wbd_d;

    logic        a_neg, b_neg;
    logic [15:0] a_mag, b_mag;
    logic [16:0] mul_sum;
    logic [16:0] div_sh;
    logic [17:0] div_diff;
    logic [31:0] prod, prod_s;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dest_d   = dest_q;
        a_d      = a_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        bz_d     = bz_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        rem_d    = rem_q;
        q_d      = q_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        wbd_d    = wbd_q;

        a_neg    = op[0] & operand_a[15];
        b_neg    = op[0] & operand_b[15];
        a_mag    = a_neg ? -operand_a : operand_a;
        b_mag    = b_neg ? -operand_b : operand_b;
        // Multiply: add-then-shift right through {rem, q}
        mul_sum  = {1'b0, rem_q[15:0]} + (q_q[0] ? {1'b0, a_q} : 17'd0);
        // Divide: restoring step, dividend bits shift out of q
        div_sh   = {rem_q[15:0], q_q[15]};
        div_diff = {1'b0, div_sh} - {2'b00, b_q};
        prod     = {rem_q[15:0], q_q};
        prod_s   = neg_q ? -prod : prod;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = 5'd0;
                    op_d    = op;
                    dest_d  = dest;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    a_raw_d = operand_a;
                    bz_d    = (operand_b == 16'h0000);
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    rem_d   = 17'd0;
                    q_d     = op[1] ? a_mag : b_mag;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[1]) begin
                    if (!div_diff[17]) begin
                        rem_d = div_diff[16:0];
                        q_d   = {q_q[14:0], 1'b1};
                    end else begin
                        rem_d = div_sh;
                        q_d   = {q_q[14:0], 1'b0};
                    end
                end else begin
                    rem_d = {1'b0, mul_sum[16:1]};
                    q_d   = {mul_sum[0], q_q[15:1]};
                end
                if (cnt_q == 5'd15) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                done_d  = 1'b1;
                wbd_d   = dest_q;
                if (!op_q[1]) begin
                    lo_d  = prod_s[15:0];
                    hi_d  = prod_s[31:16];
                    dbz_d = 1'b0;
                end else if (bz_q) begin
                    lo_d  = 16'hFFFF;
                    hi_d  = a_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = neg_q ? -q_q : q_q;
                    hi_d  = rneg_q ? -rem_q[15:0] : rem_q[15:0];
                    dbz_d = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_raw_q <= '0;
            bz_q    <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= '0;
            q_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            wbd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_raw_q <= a_raw_d;
            bz_q    <= bz_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            wbd_q   <= wbd_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign wb_en       = done_q;
    assign div_by_zero = dbz_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign wb_data     = lo_q;
    assign wb_dest     = wbd_q;

endmodule
